// File: rtl/pit_pkg.sv
// Shared encodings for the 8254-style timer bus controller: address map,
// read/write-mode field values, select codes and counter mode numbers.
package pit_pkg;

    localparam logic [1:0] ADDR_CW     = 2'd3;

    localparam logic [1:0] RW_LATCH    = 2'b00;
    localparam logic [1:0] RW_LSB      = 2'b01;
    localparam logic [1:0] RW_MSB      = 2'b10;
    localparam logic [1:0] RW_BOTH     = 2'b11;

    localparam logic [1:0] SC_READBACK = 2'b11;

    localparam logic [2:0] MODE0 = 3'd0;
    localparam logic [2:0] MODE1 = 3'd1;
    localparam logic [2:0] MODE2 = 3'd2;
    localparam logic [2:0] MODE3 = 3'd3;
    localparam logic [2:0] MODE4 = 3'd4;
    localparam logic [2:0] MODE5 = 3'd5;

    // Codes 110/111 are aliases of modes 2 and 3 on the real part.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        logic [2:0] r;
        case (m)
            3'b110:  r = MODE2;
            3'b111:  r = MODE3;
            default: r = m;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pit_cnt_regs.sv
// Per-counter programming state: rw/mode/bcd, count bytes, byte toggles, latch.
// Latency: load/cw pulses and register updates one cycle after the strobe; rd_byte is combinational.
// Backpressure: none, every strobe is accepted on the cycle it arrives.
module pit_cnt_regs
    import pit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cw_wr,
    input  logic        latch_cmd,
    input  logic        data_wr,
    input  logic        rd,
    input  logic [7:0]  din,
    input  logic [15:0] cur,
    output logic [7:0]  msb,
    output logic [7:0]  lsb,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic        load,
    output logic        cw_pulse,
    output logic [7:0]  rd_byte
);

    logic [1:0]  rw;
    logic        wr_tog;
    logic        rd_tog;
    logic        latch_vld;
    logic [15:0] latch;
    logic [15:0] src;

    assign src = latch_vld ? latch : cur;

    always_comb begin
        rd_byte = 8'h00;
        case (rw)
            RW_LSB:  rd_byte = src[7:0];
            RW_MSB:  rd_byte = src[15:8];
            RW_BOTH: rd_byte = rd_tog ? src[15:8] : src[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw        <= RW_LATCH;
            mode      <= MODE0;
            bcd       <= 1'b0;
            msb       <= 8'h00;
            lsb       <= 8'h00;
            wr_tog    <= 1'b0;
            rd_tog    <= 1'b0;
            latch_vld <= 1'b0;
            latch     <= 16'h0000;
            load      <= 1'b0;
            cw_pulse  <= 1'b0;
        end else begin
            load     <= 1'b0;
            cw_pulse <= 1'b0;
            if (cw_wr) begin
                rw        <= din[5:4];
                mode      <= norm_mode(din[3:1]);
                bcd       <= din[0];
                wr_tog    <= 1'b0;
                rd_tog    <= 1'b0;
                latch_vld <= 1'b0;
                cw_pulse  <= 1'b1;
            end else if (latch_cmd) begin
                // First latch holds until its final byte has been read.
                if (!latch_vld) begin
                    latch     <= cur;
                    latch_vld <= 1'b1;
                end
            end else if (data_wr) begin
                case (rw)
                    RW_LSB: begin
                        lsb  <= din;
                        msb  <= 8'h00;
                        load <= 1'b1;
                    end
                    RW_MSB: begin
                        msb  <= din;
                        lsb  <= 8'h00;
                        load <= 1'b1;
                    end
                    RW_BOTH: begin
                        if (!wr_tog) begin
                            lsb    <= din;
                            wr_tog <= 1'b1;
                        end else begin
                            msb    <= din;
                            wr_tog <= 1'b0;
                            load   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (rd) begin
                case (rw)
                    RW_LSB, RW_MSB: latch_vld <= 1'b0;
                    RW_BOTH: begin
                        rd_tog <= ~rd_tog;
                        if (rd_tog) latch_vld <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pit_rw_ctrl.sv
// Bus-side read/write and control-word controller for a three-counter 8254-style timer.
// Latency: dout, count registers and load/cw pulses all update on the edge sampling the strobe.
// Backpressure: none; a write wins over a simultaneous read, which is dropped with dout held.
module pit_rw_ctrl
    import pit_pkg::*;
#(
    parameter int N_CNT = 3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [1:0]             addr,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    input  logic [N_CNT*CNT_W-1:0] cnt_cur,
    output logic [N_CNT*8-1:0]     cnt_msb,
    output logic [N_CNT*8-1:0]     cnt_lsb,
    output logic [N_CNT*3-1:0]     cnt_mode,
    output logic [N_CNT-1:0]       cnt_bcd,
    output logic [N_CNT-1:0]       cnt_load,
    output logic [N_CNT-1:0]       cnt_cw_wr
);

    logic               wr_cw;
    logic               cw_is_latch;
    logic [N_CNT*8-1:0] rd_bus;
    logic [7:0]         rd_sel;

    assign wr_cw       = wr_en && (addr == ADDR_CW) && (din[7:6] != SC_READBACK);
    assign cw_is_latch = (din[5:4] == RW_LATCH);

    for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
        logic sel_cw;
        assign sel_cw = wr_cw && (din[7:6] == 2'(i));

        pit_cnt_regs u_regs (
            .clk       (clk),
            .rst       (rst),
            .cw_wr     (sel_cw && !cw_is_latch),
            .latch_cmd (sel_cw && cw_is_latch),
            .data_wr   (wr_en && (addr == 2'(i))),
            .rd        (rd_en && !wr_en && (addr == 2'(i))),
            .din       (din),
            .cur       (cnt_cur[i*CNT_W +: CNT_W]),
            .msb       (cnt_msb[i*8 +: 8]),
            .lsb       (cnt_lsb[i*8 +: 8]),
            .mode      (cnt_mode[i*3 +: 3]),
            .bcd       (cnt_bcd[i]),
            .load      (cnt_load[i]),
            .cw_pulse  (cnt_cw_wr[i]),
            .rd_byte   (rd_bus[i*8 +: 8])
        );
    end

    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < N_CNT; i++) begin
            if (addr == 2'(i)) rd_sel = rd_bus[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (rd_en && !wr_en) begin
            dout <= (addr == ADDR_CW) ? 8'h00 : rd_sel;
        end
    end

endmodule

// File: tb/tb_pit_rw_ctrl.sv
// Directed bench for pit_rw_ctrl: a bus-level model of the programming rules
// is compared with the DUT every cycle, plus hand-computed literal checks.
module tb_pit_rw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [47:0] cnt_cur;
    logic [23:0] cnt_msb, cnt_lsb;
    logic [8:0]  cnt_mode;
    logic [2:0]  cnt_bcd, cnt_load, cnt_cw_wr;

    always #5 clk = ~clk;

    pit_rw_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .cnt_cur   (cnt_cur),
        .cnt_msb   (cnt_msb),
        .cnt_lsb   (cnt_lsb),
        .cnt_mode  (cnt_mode),
        .cnt_bcd   (cnt_bcd),
        .cnt_load  (cnt_load),
        .cnt_cw_wr (cnt_cw_wr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state per counter, kept as the programmer sees it.
    logic [1:0]  m_rw  [3];
    logic [2:0]  m_mode[3];
    logic        m_bcd [3];
    logic [7:0]  m_msb [3];
    logic [7:0]  m_lsb [3];
    bit          m_wt  [3];
    bit          m_rt  [3];
    bit          m_lv  [3];
    logic [15:0] m_lat [3];
    logic [7:0]  m_dout;
    logic [2:0]  m_load, m_cw;

    logic [7:0]  e_dout;
    logic [23:0] e_msb, e_lsb;
    logic [8:0]  e_mode;
    logic [2:0]  e_bcd, e_load, e_cw;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rw[i] = 2'd0; m_mode[i] = 3'd0; m_bcd[i] = 1'b0;
            m_msb[i] = 8'h00; m_lsb[i] = 8'h00;
            m_wt[i] = 1'b0; m_rt[i] = 1'b0; m_lv[i] = 1'b0; m_lat[i] = 16'h0;
        end
        m_dout = 8'h00; m_load = 3'b000; m_cw = 3'b000;
    endtask

    task automatic model_step(input bit wr, input bit rd, input logic [1:0] a, input logic [7:0] d);
        logic [1:0]  sc;
        logic [15:0] src;
        m_load = 3'b000;
        m_cw   = 3'b000;
        if (wr) begin
            if (a == 2'd3) begin
                sc = d[7:6];
                if (sc != 2'd3) begin
                    if (d[5:4] != 2'd0) begin
                        m_rw[sc]   = d[5:4];
                        m_mode[sc] = (d[3:1] > 3'd5) ? d[3:1] - 3'd4 : d[3:1];
                        m_bcd[sc]  = d[0];
                        m_wt[sc] = 1'b0; m_rt[sc] = 1'b0; m_lv[sc] = 1'b0;
                        m_cw[sc] = 1'b1;
                    end else if (!m_lv[sc]) begin
                        m_lat[sc] = cnt_cur[sc*16 +: 16];
                        m_lv[sc]  = 1'b1;
                    end
                end
            end else begin
                case (m_rw[a])
                    2'd1: begin m_lsb[a] = d; m_msb[a] = 8'h00; m_load[a] = 1'b1; end
                    2'd2: begin m_msb[a] = d; m_lsb[a] = 8'h00; m_load[a] = 1'b1; end
                    2'd3: begin
                        if (!m_wt[a]) begin m_lsb[a] = d; m_wt[a] = 1'b1; end
                        else begin m_msb[a] = d; m_wt[a] = 1'b0; m_load[a] = 1'b1; end
                    end
                    default: ;
                endcase
            end
        end else if (rd) begin
            if (a == 2'd3) begin
                m_dout = 8'h00;
            end else begin
                src = m_lv[a] ? m_lat[a] : cnt_cur[a*16 +: 16];
                case (m_rw[a])
                    2'd1: begin m_dout = 8'(src % 16'd256); m_lv[a] = 1'b0; end
                    2'd2: begin m_dout = 8'(src / 16'd256); m_lv[a] = 1'b0; end
                    2'd3: begin
                        if (!m_rt[a]) begin m_dout = 8'(src % 16'd256); m_rt[a] = 1'b1; end
                        else begin m_dout = 8'(src / 16'd256); m_rt[a] = 1'b0; m_lv[a] = 1'b0; end
                    end
                    default: m_dout = 8'h00;
                endcase
            end
        end
    endtask

    task automatic commit();
        e_dout = m_dout;
        e_msb  = {m_msb[2], m_msb[1], m_msb[0]};
        e_lsb  = {m_lsb[2], m_lsb[1], m_lsb[0]};
        e_mode = {m_mode[2], m_mode[1], m_mode[0]};
        e_bcd  = {m_bcd[2], m_bcd[1], m_bcd[0]};
        e_load = m_load;
        e_cw   = m_cw;
    endtask

    // One bus cycle: drive, advance the model, take the edge, publish expectations.
    task automatic cyc(input bit wr, input bit rd, input logic [1:0] a, input logic [7:0] d);
        wr_en = wr; rd_en = rd; addr = a; din = d;
        model_step(wr, rd, a, d);
        @(posedge clk);
        #1;
        commit();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    bit chk_on = 1'b0;
    int ld_cnt[3];
    int cw_cnt[3];

    always @(negedge clk) begin
        if (chk_on) begin
            check("dout",      48'(dout),      48'(e_dout));
            check("cnt_msb",   48'(cnt_msb),   48'(e_msb));
            check("cnt_lsb",   48'(cnt_lsb),   48'(e_lsb));
            check("cnt_mode",  48'(cnt_mode),  48'(e_mode));
            check("cnt_bcd",   48'(cnt_bcd),   48'(e_bcd));
            check("cnt_load",  48'(cnt_load),  48'(e_load));
            check("cnt_cw_wr", 48'(cnt_cw_wr), 48'(e_cw));
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt_load[i])  ld_cnt[i]++;
                    if (cnt_cw_wr[i]) cw_cnt[i]++;
                end
            end
        end
    end

    int ld0_before;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; din = 8'h00;
        cnt_cur = 48'h0;
        for (int i = 0; i < 3; i++) begin ld_cnt[i] = 0; cw_cnt[i] = 0; end
        model_reset();
        commit();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 48'(dout),      48'h0);
        check("rst_msb",  48'(cnt_msb),   48'h0);
        check("rst_lsb",  48'(cnt_lsb),   48'h0);
        check("rst_mode", 48'(cnt_mode),  48'h0);
        check("rst_load", 48'(cnt_load),  48'h0);
        check("rst_cw",   48'(cnt_cw_wr), 48'h0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Counter 1, LSB then MSB, mode 1.
        cyc(1, 0, 2'd3, 8'h72);
        check("cw1_pulse", 48'(cnt_cw_wr), 48'(3'b010));
        check("mode1", 48'(cnt_mode[5:3]), 48'(3'b001));
        cyc(1, 0, 2'd1, 8'h34);
        check("load1_after_lsb", 48'(cnt_load), 48'h0);
        cyc(1, 0, 2'd1, 8'h12);
        check("load1_after_msb", 48'(cnt_load), 48'(3'b010));
        check("count1", 48'({cnt_msb[15:8], cnt_lsb[15:8]}), 48'h1234);
        cyc(0, 0, 2'd0, 8'h00);
        check("cw1_pulses", 48'(cw_cnt[1]), 48'd1);
        check("ld1_pulses", 48'(ld_cnt[1]), 48'd1);

        // Counter 0, LSB only.
        cyc(1, 0, 2'd3, 8'h10);
        cyc(1, 0, 2'd0, 8'h05);
        check("lsb0", 48'(cnt_lsb[7:0]), 48'h05);
        check("msb0", 48'(cnt_msb[7:0]), 48'h00);
        check("load0", 48'(cnt_load), 48'(3'b001));

        // Mode aliases 110/111 and BCD flag.
        cyc(1, 0, 2'd3, 8'h1C);
        check("mode0_alias6", 48'(cnt_mode[2:0]), 48'(3'b010));
        cyc(1, 0, 2'd3, 8'h1F);
        check("mode0_alias7", 48'(cnt_mode[2:0]), 48'(3'b011));
        check("bcd0", 48'(cnt_bcd), 48'(3'b001));

        // Latch on counter 2: first latch wins, then live readback.
        cnt_cur[47:32] = 16'hABCD;
        cyc(1, 0, 2'd3, 8'hB0);
        cyc(1, 0, 2'd3, 8'h80);
        cnt_cur[47:32] = 16'h1111;
        cyc(1, 0, 2'd3, 8'h80);
        cyc(0, 1, 2'd2, 8'h00);
        check("latch_lsb", 48'(dout), 48'hCD);
        cyc(0, 1, 2'd2, 8'h00);
        check("latch_msb", 48'(dout), 48'hAB);
        cyc(0, 1, 2'd2, 8'h00);
        check("live_lsb", 48'(dout), 48'h11);

        // A new control word restarts the write byte order.
        ld0_before = ld_cnt[0];
        cyc(1, 0, 2'd3, 8'h30);
        cyc(1, 0, 2'd0, 8'h99);
        cyc(1, 0, 2'd3, 8'h30);
        cyc(1, 0, 2'd0, 8'h01);
        cyc(1, 0, 2'd0, 8'h00);
        cyc(0, 0, 2'd0, 8'h00);
        check("reorder_lsb0", 48'(cnt_lsb[7:0]), 48'h01);
        check("reorder_msb0", 48'(cnt_msb[7:0]), 48'h00);
        check("reorder_loads", 48'(ld_cnt[0] - ld0_before), 48'd1);

        // Simultaneous read and write: write wins, dout holds.
        cyc(1, 1, 2'd0, 8'h77);
        check("rw_same_dout", 48'(dout), 48'h11);
        check("rw_same_lsb0", 48'(cnt_lsb[7:0]), 48'h77);
        cyc(1, 0, 2'd3, 8'hC0);
        check("readback_cw", 48'(cnt_cw_wr), 48'h0);
        cyc(0, 1, 2'd3, 8'h00);
        check("read_cw_addr", 48'(dout), 48'h00);

        // Reset with counter 1 halfway through a two-byte write.
        cyc(1, 0, 2'd3, 8'h70);
        cyc(1, 0, 2'd1, 8'h55);
        check("pre_rst_lsb1", 48'(cnt_lsb[15:8]), 48'h55);
        #2;
        rst = 1'b1;
        model_reset();
        commit();
        #1;
        check("arst_msb",  48'(cnt_msb),   48'h0);
        check("arst_lsb",  48'(cnt_lsb),   48'h0);
        check("arst_mode", 48'(cnt_mode),  48'h0);
        check("arst_dout", 48'(dout),      48'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 2'd1, 8'hAA);
        cyc(1, 0, 2'd1, 8'hBB);
        check("unprog_lsb", 48'(cnt_lsb), 48'h0);
        check("unprog_msb", 48'(cnt_msb), 48'h0);
        cyc(1, 0, 2'd3, 8'h50);
        cyc(1, 0, 2'd1, 8'h42);
        check("reprog_lsb1", 48'(cnt_lsb[15:8]), 48'h42);
        check("reprog_load", 48'(cnt_load), 48'(3'b010));
        cyc(0, 0, 2'd0, 8'h00);
        cyc(0, 0, 2'd0, 8'h00);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pit_rw_ctrl.md
Name: pit_rw_ctrl

Overview:
- Bus-side read/write and control-word controller for the 8254-style timer. It configures and sequences three counter cores: Mode0..Mode5 blocks such as Mode1.
- Decodes control words, steers LSB/MSB data bytes into per-counter count registers and issues load strobes.
- Implements the counter-latch command and byte-ordered readback of live or latched counts.
- Sits between the CPU bus model and the three counter instances.

Parameters:
- N_CNT, 3, number of counters; fixed by the 2-bit address map (addr 0..2 = counters, 3 = control).
- CNT_W, 16, count width per counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  write strobe, one cycle per byte.
- rd_en  in  1  read strobe, one cycle per byte.
- addr  in  2  0/1/2 select a counter, 3 selects the control word.
- din  in  8  write data.
- dout  out  8  registered read data.
- cnt_cur  in  48  live counts from the counters, {c2,c1,c0}, 16 bits each.
- cnt_msb  out  24  programmed MSB per counter, {c2,c1,c0}.
- cnt_lsb  out  24  programmed LSB per counter.
- cnt_mode  out  9  3-bit mode per counter.
- cnt_bcd  out  3  BCD flag per counter (stored only; counters ignore it).
- cnt_load  out  3  one-cycle pulse per counter when a full count has been written.
- cnt_cw_wr  out  3  one-cycle pulse per counter when its control word is written (counter returns to idle, out high).

Behaviour:
- Reset (async, immediate): dout=0; cnt_msb, cnt_lsb, cnt_mode and cnt_bcd all 0; cnt_load and cnt_cw_wr 0. Per-counter rw field=00 (unprogrammed); write toggle, read toggle, latch-valid flag and latch register all cleared. Reset mid-sequence discards any staged byte.
- Control word (wr_en, addr=3), fields SC=din[7:6], RW=din[5:4], M=din[3:1], BCD=din[0]:
  - SC=11 (read-back) is ignored: no state change.
  - RW!=00: store rw, mode and bcd for counter SC. Modes 110 and 111 store as 010 and 011. Clear that counter's write toggle, read toggle and latch-valid. Pulse cnt_cw_wr[SC] on the next cycle. cnt_msb and cnt_lsb are unchanged.
  - RW=00 (latch command): if latch-valid=0, capture cnt_cur[SC] into the latch register and set latch-valid. If latch-valid=1, ignore; the first latch wins until it has been read.
- Data write (wr_en, addr=c<3):
  - rw=00: ignored.
  - rw=01: lsb=din, msb=00, pulse cnt_load[c].
  - rw=10: msb=din, lsb=00, pulse cnt_load[c].
  - rw=11, write toggle=0: lsb=din, toggle becomes 1, no load pulse.
  - rw=11, write toggle=1: msb=din, toggle becomes 0, pulse cnt_load[c].
- cnt_load and cnt_cw_wr are registered. They assert in the cycle after the strobe, coincident with the updated cnt_msb/cnt_lsb/cnt_mode, and last exactly one cycle.
- Read (rd_en, addr=c<3): dout updates on the edge that samples rd_en, so data is visible the cycle after the strobe.
  - Source is the latch register if latch-valid=1, else cnt_cur[c].
  - rw=01 returns the LSB; rw=10 returns the MSB.
  - rw=11 returns the LSB then the MSB, alternating on the read toggle.
  - Latch-valid clears after the final byte of the sequence: the single read for rw=01/10, the MSB read for rw=11.
  - rw=00 returns 0x00.
- Read with addr=3 returns 0x00.
- rd_en and wr_en in the same cycle: the write is performed, the read is ignored and dout holds.
- A control word to counter X never disturbs the toggles, latch or registers of other counters.
- Back-to-back strobes on consecutive cycles are all accepted. There is no busy state.

Decomposition:
- Package pit_pkg holds:
  - address constants: ADDR_CW=2'd3;
  - RW encodings: RW_LATCH=00, RW_LSB=01, RW_MSB=10, RW_BOTH=11;
  - SC_READBACK=11;
  - mode encodings MODE0..MODE5.
- Sub-module pit_cnt_regs holds one counter's rw, mode, bcd, msb, lsb, write and read toggles, latch, and its load/cw pulses. It is instantiated N_CNT times. The top level does address decode and the dout mux.

Test Plan:
- Write control 0x72 (ctr1, RW=11, mode1), then data writes 0x34 and 0x12 to addr 1:
  - cnt_cw_wr[1] pulses once.
  - cnt_load[1] pulses only after the second byte.
  - cnt_mode[5:3]=001 and {msb,lsb}=0x1234.
- Write control 0x10 (ctr0, RW=01), then data 0x05 to addr 0 → lsb0=0x05, msb0=0x00, cnt_load[0] pulses.
- Latch test on ctr2 (configured RW=11), with cnt_cur[2]=0xABCD:
  - Write latch 0x80, then change cnt_cur to 0x1111 and write latch 0x80 again.
  - Read addr 2 twice → 0xCD then 0xAB.
  - A third read returns the live LSB 0x11.
- Byte-order reset: ctr0 RW=11, write one byte 0x99, then rewrite control word 0x30, then write 0x01 and 0x00:
  - lsb=0x01, msb=0x00, exactly one cnt_load[0] pulse.
- Same-cycle wr_en and rd_en to addr 0 → write takes effect, dout unchanged. Then control word 0xC0 (read-back) → no output changes.
- Assert rst while the ctr1 write toggle=1:
  - All outputs 0 immediately.
  - After release, data writes to addr 1 are ignored until a control word is written.
